dma_chunk_scheduler: RTL and testbench

Top-level sequencer for one DMA channel. Accepts a single copy command (source, destination, byte length) and splits it into chunks that never cross a 4 KB boundary on either side and never exceed MAX_CHUNK bytes. For each chunk it starts the Read Master and Write Master together, waits for both done indications, then advances. Reports busy/done/error status and a sticky interrupt to the register/CSR layer.

---
 rtl/dma_pkg.sv | 18 +
 rtl/dma_chunk_calc.sv | 39 +++
 rtl/dma_chunk_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_dma_chunk_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA chunk scheduler.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_CALC   = 3'd2,
    ST_LAUNCH = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } dma_state_e;

  localparam int unsigned DMA_BOUNDARY  = 4096;
  localparam int unsigned DMA_MAX_CHUNK = 1024;
  localparam logic [1:0]  ALIGN_MASK    = 2'b11;

endpackage

// File: rtl/dma_chunk_calc.sv
// Combinational chunk length: min of remaining bytes, max chunk size and the
// distance of source and destination to their next burst boundary.
module dma_chunk_calc #(
  parameter int unsigned LEN_W     = 32,
  parameter int unsigned OFF_W     = 12,
  parameter int unsigned MAX_CHUNK = 1024,
  parameter int unsigned BOUNDARY  = 4096
) (
  input  logic [LEN_W-1:0] i_remaining,
  input  logic [OFF_W-1:0] i_src_off,
  input  logic [OFF_W-1:0] i_dst_off,
  output logic [LEN_W-1:0] o_chunk_c
);

  localparam int unsigned CW = LEN_W + 1;

  logic [CW-1:0] rem_w;
  logic [CW-1:0] max_w;
  logic [CW-1:0] src_gap;
  logic [CW-1:0] dst_gap;
  logic [CW-1:0] min_a;
  logic [CW-1:0] min_b;
  logic [CW-1:0] min_all;
  logic          unused_msb;

  always_comb begin
    rem_w      = CW'(i_remaining);
    max_w      = CW'(MAX_CHUNK);
    src_gap    = CW'(BOUNDARY) - CW'(i_src_off);
    dst_gap    = CW'(BOUNDARY) - CW'(i_dst_off);
    min_a      = (rem_w < max_w) ? rem_w : max_w;
    min_b      = (src_gap < dst_gap) ? src_gap : dst_gap;
    min_all    = (min_a < min_b) ? min_a : min_b;
    // Result never exceeds i_remaining, so the extra bit is always zero.
    o_chunk_c  = min_all[LEN_W-1:0];
    unused_msb = min_all[CW-1];
  end

endmodule

// File: rtl/dma_chunk_scheduler.sv
// Single-channel DMA sequencer: splits one copy command into boundary-safe chunks
// and drives the read/write masters. Optional counters under DMA_SCHED_PERF_EN.
module dma_chunk_scheduler
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 32,
  parameter int unsigned MAX_CHUNK = DMA_MAX_CHUNK,
  parameter int unsigned BOUNDARY  = DMA_BOUNDARY
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W-1:0] i_dst_addr,
  input  logic [LEN_W-1:0]  i_total_len,
  input  logic              i_irq_clr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic              o_irq,
  output logic              o_rd_start,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [LEN_W-1:0]  o_rd_len,
  input  logic              i_rd_done,
  input  logic              i_rd_err,
  output logic              o_wr_start,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [LEN_W-1:0]  o_wr_len,
  input  logic              i_wr_done,
  input  logic              i_wr_err
`ifdef DMA_SCHED_PERF_EN
  ,
  output logic [31:0]       o_cycle_cnt,
  output logic [15:0]       o_chunk_cnt
`endif
);

  localparam int unsigned OFF_W = $clog2(BOUNDARY);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              rd_seen_q, rd_seen_d;
  logic              wr_seen_q, wr_seen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              irq_q, irq_d;
  logic              start_q, start_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  chunk_c;
  logic              rd_eff, wr_eff, err_in, accept, advance;

  dma_chunk_calc #(
    .LEN_W     (LEN_W),
    .OFF_W     (OFF_W),
    .MAX_CHUNK (MAX_CHUNK),
    .BOUNDARY  (BOUNDARY)
  ) u_calc (
    .i_remaining (rem_q),
    .i_src_off   (src_q[OFF_W-1:0]),
    .i_dst_off   (dst_q[OFF_W-1:0]),
    .o_chunk_c   (chunk_c)
  );

  assign rd_eff  = rd_seen_q | i_rd_done;
  assign wr_eff  = wr_seen_q | i_wr_done;
  assign err_in  = i_rd_err | i_wr_err;
  assign accept  = (state_q == ST_IDLE) && i_start;
  assign advance = (state_q == ST_WAIT) && rd_eff && wr_eff && !err_in;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a master error in any busy state overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (i_start) state_d = ST_CHECK;
      ST_CHECK: begin
        if ((rem_q == '0) || ((src_q[1:0] & ALIGN_MASK) != 2'b00) ||
            ((dst_q[1:0] & ALIGN_MASK) != 2'b00) || ((rem_q[1:0] & ALIGN_MASK) != 2'b00))
          state_d = ST_ERR;
        else
          state_d = ST_CALC;
      end
      ST_CALC:   state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (rd_eff && wr_eff) state_d = (rem_q == len_q) ? ST_DONE : ST_CALC;
      ST_DONE:   state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (err_in && (state_q inside {ST_CHECK, ST_CALC, ST_LAUNCH, ST_WAIT}))
      state_d = ST_ERR;
  end

  // Output and datapath next values, keyed on the upcoming state
  always_comb begin
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    len_d     = len_q;
    error_d   = error_q;
    irq_d     = irq_q;
    rd_seen_d = (state_d == ST_WAIT) ? rd_eff : 1'b0;
    wr_seen_d = (state_d == ST_WAIT) ? wr_eff : 1'b0;
    busy_d    = state_d inside {ST_CHECK, ST_CALC, ST_LAUNCH, ST_WAIT};
    done_d    = (state_d == ST_DONE);
    start_d   = (state_d == ST_LAUNCH);
    if (accept) begin
      src_d   = i_src_addr;
      dst_d   = i_dst_addr;
      rem_d   = i_total_len;
      error_d = 1'b0;
    end
    if (state_q == ST_CALC) begin
      len_d     = chunk_c;
      rd_addr_d = src_q;
      wr_addr_d = dst_q;
    end
    if (advance) begin
      src_d = src_q + ADDR_W'(len_q);
      dst_d = dst_q + ADDR_W'(len_q);
      rem_d = rem_q - len_q;
    end
    if (state_d == ST_ERR) error_d = 1'b1;
    if ((state_d == ST_DONE) || (state_d == ST_ERR)) irq_d = 1'b1;
    else if (i_irq_clr)                               irq_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      rd_seen_q <= 1'b0;
      wr_seen_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      irq_q     <= 1'b0;
      start_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      len_q     <= '0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      rd_seen_q <= rd_seen_d;
      wr_seen_q <= wr_seen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      irq_q     <= irq_d;
      start_q   <= start_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      len_q     <= len_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_irq      = irq_q;
  assign o_rd_start = start_q;
  assign o_wr_start = start_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_rd_len   = len_q;
  assign o_wr_len   = len_q;

`ifdef DMA_SCHED_PERF_EN
  localparam int unsigned CYC_W = 32;
  localparam int unsigned CHK_W = 16;

  logic [CYC_W-1:0] cycle_cnt_q;
  logic [CHK_W-1:0] chunk_cnt_q;

  // Counters restart per command and freeze once the command ends
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_cnt_q <= '0;
      chunk_cnt_q <= '0;
    end else if (accept) begin
      cycle_cnt_q <= '0;
      chunk_cnt_q <= '0;
    end else begin
      if (busy_q && (cycle_cnt_q != '1)) cycle_cnt_q <= cycle_cnt_q + CYC_W'(1);
      if (state_q == ST_LAUNCH)          chunk_cnt_q <= chunk_cnt_q + CHK_W'(1);
    end
  end

  assign o_cycle_cnt = cycle_cnt_q;
  assign o_chunk_cnt = chunk_cnt_q;
`endif

endmodule

// File: tb/tb_dma_chunk_scheduler.sv
// Randomized self-checking bench for dma_chunk_scheduler against a chunk-list model.
module tb_dma_chunk_scheduler;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 32;
  localparam int unsigned MAXC   = 1024;
  localparam int unsigned BND    = 4096;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_start, i_irq_clr;
  logic [ADDR_W-1:0] i_src_addr, i_dst_addr;
  logic [LEN_W-1:0]  i_total_len;
  logic              o_busy, o_done, o_error, o_irq;
  logic              o_rd_start, o_wr_start;
  logic [ADDR_W-1:0] o_rd_addr, o_wr_addr;
  logic [LEN_W-1:0]  o_rd_len, o_wr_len;
  logic              i_rd_done, i_rd_err, i_wr_done, i_wr_err;

  always #5 clk = ~clk;

  dma_chunk_scheduler #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_CHUNK(MAXC), .BOUNDARY(BND)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start),
    .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr), .i_total_len(i_total_len),
    .i_irq_clr(i_irq_clr), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_irq(o_irq), .o_rd_start(o_rd_start), .o_rd_addr(o_rd_addr), .o_rd_len(o_rd_len),
    .i_rd_done(i_rd_done), .i_rd_err(i_rd_err), .o_wr_start(o_wr_start),
    .o_wr_addr(o_wr_addr), .o_wr_len(o_wr_len), .i_wr_done(i_wr_done), .i_wr_err(i_wr_err)
  );

  int total = 0;
  int bad   = 0;
  int rd_start_cnt = 0;
  int done_cnt     = 0;

  longint unsigned exp_src[$];
  longint unsigned exp_dst[$];
  longint unsigned exp_len[$];
  bit              exp_bad;

  always @(posedge clk) begin
    if (o_rd_start) rd_start_cnt++;
    if (o_done)     done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: list of chunks from the splitting rules, addresses modulo 2^32
  function automatic void build_model(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    longint unsigned cs, cd, rem, c, g;
    exp_src.delete(); exp_dst.delete(); exp_len.delete();
    exp_bad = (l == 0) || (s % 4 != 0) || (d % 4 != 0) || (l % 4 != 0);
    cs = s; cd = d; rem = l;
    if (!exp_bad) begin
      while (rem > 0) begin
        c = rem;
        if (c > MAXC) c = MAXC;
        g = BND - (cs % BND); if (g < c) c = g;
        g = BND - (cd % BND); if (g < c) c = g;
        exp_src.push_back(cs); exp_dst.push_back(cd); exp_len.push_back(c);
        cs = (cs + c) % 64'h1_0000_0000;
        cd = (cd + c) % 64'h1_0000_0000;
        rem = rem - c;
      end
    end
  endfunction

  // order: 0 random, 1 wr first, 2 same cycle, 3 rd first, 4 alternate wr-first/same
  task automatic run_cmd(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                         input int order, input int err_chunk, input bit clr_with_start);
    int starts0, dones0, n, exp_lat, m, drd, dwr, last;
    bit aborted, inject, final_chunk, clr_same;
    build_model(src, dst, len);
    starts0 = rd_start_cnt;
    dones0  = done_cnt;
    @(negedge clk);
    i_start = 1'b1; i_src_addr = src; i_dst_addr = dst; i_total_len = len; i_irq_clr = clr_with_start;
    @(negedge clk);
    i_start = 1'b0; i_irq_clr = 1'b0;
    i_src_addr = $urandom; i_dst_addr = $urandom; i_total_len = $urandom;
    chk("busy_on_start", o_busy, 1);
    chk("err_clr_on_start", o_error, 0);
    if (clr_with_start) chk("irq_clr_on_start", o_irq, 0);
    if (exp_bad) begin
      @(negedge clk);
      chk("bad_err", o_error, 1);
      chk("bad_irq", o_irq, 1);
      chk("bad_busy", o_busy, 0);
      chk("bad_done", o_done, 0);
      repeat (4) @(negedge clk);
      chk("bad_no_start", rd_start_cnt - starts0, 0);
    end else begin
      aborted = 0;
      exp_lat = 3;
      for (int i = 0; i < exp_len.size() && !aborted; i++) begin
        n = 1;
        while (!o_rd_start && n < 16) begin @(negedge clk); n++; end
        chk("launch_lat", n, exp_lat);
        chk("wr_start", o_wr_start, 1);
        chk("rd_addr", o_rd_addr, exp_src[i]);
        chk("wr_addr", o_wr_addr, exp_dst[i]);
        chk("rd_len", o_rd_len, exp_len[i]);
        chk("wr_len", o_wr_len, exp_len[i]);
        m = (order == 4) ? ((i % 2 == 0) ? 1 : 2) : ((order == 0) ? $urandom_range(1, 3) : order);
        case (m)
          1:       begin dwr = $urandom_range(0, 2); drd = dwr + 1 + $urandom_range(0, 1); end
          3:       begin drd = $urandom_range(0, 2); dwr = drd + 1 + $urandom_range(0, 1); end
          default: begin drd = $urandom_range(0, 3); dwr = drd; end
        endcase
        inject = (i == err_chunk);
        if (inject) begin drd = 0; dwr = 1; end
        last = (drd > dwr) ? drd : dwr;
        final_chunk = (i == exp_len.size() - 1);
        clr_same = final_chunk && !inject && ($urandom_range(0, 1) == 1);
        for (int k = 0; k <= last; k++) begin
          @(negedge clk);
          i_rd_done  = (k == drd);
          i_wr_done  = (k == dwr);
          i_wr_err   = inject && (k == dwr);
          i_start    = ($urandom_range(0, 1) == 1);
          i_src_addr = $urandom;
          i_irq_clr  = clr_same && (k == last);
        end
        @(negedge clk);
        i_rd_done = 1'b0; i_wr_done = 1'b0; i_wr_err = 1'b0; i_start = 1'b0; i_irq_clr = 1'b0;
        if (inject) begin
          chk("err_flag", o_error, 1);
          chk("err_busy", o_busy, 0);
          chk("err_done", o_done, 0);
          chk("err_irq", o_irq, 1);
          repeat (5) @(negedge clk);
          chk("err_no_more_start", rd_start_cnt - starts0, i + 1);
          chk("err_no_done_pulse", done_cnt - dones0, 0);
          aborted = 1;
        end else if (final_chunk) begin
          chk("done_pulse", o_done, 1);
          chk("done_busy", o_busy, 0);
          chk("done_irq", o_irq, 1);
          @(negedge clk);
          chk("done_width", o_done, 0);
        end else begin
          chk("mid_done", o_done, 0);
          chk("mid_busy", o_busy, 1);
          exp_lat = 2;
        end
      end
      if (!aborted) begin
        chk("start_count", rd_start_cnt - starts0, exp_len.size());
        chk("done_count", done_cnt - dones0, 1);
      end
    end
    @(negedge clk); i_irq_clr = 1'b1;
    @(negedge clk); i_irq_clr = 1'b0;
    chk("irq_clr", o_irq, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {o_busy, o_done, o_error, o_irq, o_rd_start, o_wr_start}, 0);
    chk({tag, "_rd"}, {o_rd_addr, o_rd_len}, 0);
    chk({tag, "_wr"}, {o_wr_addr, o_wr_len}, 0);
  endtask

  initial begin
    logic [31:0] s, d, l;
    int r, n, starts0;
    reset_n = 1'b0; i_start = 1'b0; i_irq_clr = 1'b0;
    i_src_addr = '0; i_dst_addr = '0; i_total_len = '0;
    i_rd_done = 1'b0; i_rd_err = 1'b0; i_wr_done = 1'b0; i_wr_err = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    run_cmd(32'h1000_0000, 32'hC000_0000, 32'd64, 0, -1, 1'b0);
    run_cmd(32'h1000_0F80, 32'hC000_0000, 32'd512, 3, -1, 1'b0);
    run_cmd(32'h0, 32'h0, 32'd3000, 4, -1, 1'b0);
    run_cmd(32'h1000, 32'h2000, 32'd0, 0, -1, 1'b0);
    run_cmd(32'h2, 32'h2000, 32'd64, 0, -1, 1'b0);
    run_cmd(32'h4000, 32'h8000, 32'd128, 0, -1, 1'b1);
    run_cmd(32'h3000, 32'h4000, 32'd256, 0, 0, 1'b0);
    run_cmd(32'hFFFF_FF00, 32'h0000_0F00, 32'd1024, 0, -1, 1'b0);

    // Reset while a multi-chunk transfer is waiting on the masters
    @(negedge clk);
    i_start = 1'b1; i_src_addr = '0; i_dst_addr = '0; i_total_len = 32'd3000;
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (!o_rd_start && n < 16) begin @(negedge clk); n++; end
    chk("rst_pre_launch", o_rd_start, 1);
    @(negedge clk);
    i_rd_done = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    i_rd_done = 1'b0;
    check_all_zero("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    starts0 = rd_start_cnt;
    repeat (4) @(negedge clk);
    chk("rst_no_start", rd_start_cnt - starts0, 0);
    run_cmd(32'h0, 32'h0, 32'd3000, 0, -1, 1'b0);

    for (int t = 0; t < 25; t++) begin
      r = $urandom_range(0, 9);
      s = $urandom & 32'hFFFF_FFFC;
      d = $urandom & 32'hFFFF_FFFC;
      l = 32'($urandom_range(1, 800)) * 32'd4;
      if (r == 0) l = 32'd0;
      if (r == 1) s = s | 32'd1;
      if (r == 2) l = l | 32'd2;
      if (r == 3) s = 32'hFFFF_FF00;
      if (r == 4) d = d | 32'hFC0;
      run_cmd(s, d, l, 0, ($urandom_range(0, 5) == 0) ? 0 : -1, ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
